// File: rtl/mvu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvu_pkg
// Purpose  : Shared widths and job-state encoding for the MVU output path.
// Revision : 1.0 - initial release
// ============================================================================
package mvu_pkg;

    localparam int BDBANKA = 15;   // data bank address width
    localparam int BPREC   = 6;    // precision field width
    localparam int BLENGTH = 15;   // length field width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/outfifo.sv
`default_nettype none
// ============================================================================
// Module   : outfifo
// Purpose  : Small synchronous word FIFO with head look-ahead. A push into a
//            full FIFO is accepted when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module outfifo #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

    logic [N-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_push_ok;
    logic         w_pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (r_wp == r_rp);
    assign full      = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign head      = r_mem[r_rp[AW-1:0]];

    // Pointer update; clear and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + c_ptr_one;
            if (w_pop_ok)  r_rp <= r_rp + c_ptr_one;
        end
    end

    // Storage write; when full the slot written is the one being popped.
    always_ff @(posedge clk) begin
        if (w_push_ok && !(clr || flush)) begin
            r_mem[r_wp[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/outagu.sv
`default_nettype none
// ============================================================================
// Module   : outagu
// Purpose  : Output address generator and write buffer behind an MVU
//            quantizer. Buffers bit-plane words and writes them to data
//            memory along a 3-D strided address pattern.
// Revision : 1.0 - initial release
// ============================================================================
module outagu
    import mvu_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [BPREC-1:0]   oprecision,
    input  logic [BDBANKA-1:0] obaseaddr,
    input  logic [BDBANKA-1:0] ostride0,
    input  logic [BDBANKA-1:0] ostride1,
    input  logic [BDBANKA-1:0] ostride2,
    input  logic [BLENGTH-1:0] olength0,
    input  logic [BLENGTH-1:0] olength1,
    input  logic [BLENGTH-1:0] olength2,
    input  logic               quant_valid,
    input  logic [N-1:0]       quant_word,
    output logic               wrd_en,
    input  logic               wrd_grnt,
    output logic [BDBANKA-1:0] wrd_addr,
    output logic [N-1:0]       wrd_word,
    output logic               busy,
    output logic               done,
    output logic               err_ovf
);

    localparam logic [BPREC-1:0]   c_bit_one = BPREC'(1);
    localparam logic [BLENGTH-1:0] c_len_one = BLENGTH'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BPREC-1:0]   r_prec;
    logic [BDBANKA-1:0] r_base;
    logic [BDBANKA-1:0] r_stride0, r_stride1, r_stride2;
    logic [BLENGTH-1:0] r_len0, r_len1, r_len2;
    logic [BPREC-1:0]   r_bit;
    logic [BLENGTH-1:0] r_cnt0, r_cnt1, r_cnt2;
    logic [BDBANKA-1:0] r_ptr;
    logic               r_err;

    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_acc;
    logic               w_vec_end;
    logic               w_last;
    logic [N-1:0]       w_head;

    assign w_run      = (r_state == RUN);
    assign w_pop      = w_run & ~w_empty & wrd_grnt;
    assign w_push_acc = w_run & (~w_full | w_pop);
    assign w_vec_end  = (r_bit == r_prec - c_bit_one);
    assign w_last     = w_vec_end && (r_cnt0 == r_len0) && (r_cnt1 == r_len1)
                        && (r_cnt2 == r_len2);

    outfifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .flush (start),
        .push  (quant_valid & w_run),
        .pop   (w_pop),
        .din   (quant_word),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and outputs; start restarts the job from any state.
    always_comb begin
        w_state_nxt = r_state;
        wrd_en      = 1'b0;
        wrd_word    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: ;
            RUN: begin
                busy   = 1'b1;
                wrd_en = ~w_empty;
                if (w_pop && w_last) w_state_nxt = DONE;
            end
            ZERO: begin
                busy        = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (start) w_state_nxt = (oprecision == '0) ? ZERO : RUN;
        if (wrd_en) wrd_word = w_head;
    end

    // Config latch and odometer counters, advanced on every accepted write.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_prec    <= '0;
            r_base    <= '0;
            r_stride0 <= '0;
            r_stride1 <= '0;
            r_stride2 <= '0;
            r_len0    <= '0;
            r_len1    <= '0;
            r_len2    <= '0;
            r_bit     <= '0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_ptr     <= '0;
        end else if (start) begin
            r_prec    <= oprecision;
            r_base    <= obaseaddr;
            r_stride0 <= ostride0;
            r_stride1 <= ostride1;
            r_stride2 <= ostride2;
            r_len0    <= olength0;
            r_len1    <= olength1;
            r_len2    <= olength2;
            r_bit     <= '0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_ptr     <= '0;
        end else if (w_pop) begin
            if (!w_vec_end) begin
                r_bit <= r_bit + c_bit_one;
            end else begin
                r_bit <= '0;
                if (r_cnt0 != r_len0) begin
                    r_cnt0 <= r_cnt0 + c_len_one;
                    r_ptr  <= r_ptr + r_stride0;
                end else begin
                    r_cnt0 <= '0;
                    if (r_cnt1 != r_len1) begin
                        r_cnt1 <= r_cnt1 + c_len_one;
                        r_ptr  <= r_ptr + r_stride1;
                    end else begin
                        r_cnt1 <= '0;
                        if (r_cnt2 != r_len2) begin
                            r_cnt2 <= r_cnt2 + c_len_one;
                            r_ptr  <= r_ptr + r_stride2;
                        end
                    end
                end
            end
        end
    end

    // Sticky overflow: any valid word that the FIFO does not accept.
    always_ff @(posedge clk) begin
        if (clr || start)                   r_err <= 1'b0;
        else if (quant_valid && !w_push_acc) r_err <= 1'b1;
    end

    assign wrd_addr = r_base + r_ptr + BDBANKA'(r_bit);
    assign err_ovf  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_outagu.sv
`default_nettype none
// ============================================================================
// Module   : tb_outagu
// Purpose  : Self-checking bench for outagu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_outagu;

    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int P_IDLE = 0, P_RUN = 1, P_ZERO = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          clr, start, quant_valid, wrd_grnt;
    logic [5:0]    oprecision;
    logic [14:0]   obaseaddr, ostride0, ostride1, ostride2;
    logic [14:0]   olength0, olength1, olength2;
    logic [N-1:0]  quant_word;
    logic          wrd_en, busy, done, err_ovf;
    logic [14:0]   wrd_addr;
    logic [N-1:0]  wrd_word;

    always #5 clk = ~clk;

    outagu #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .start(start), .oprecision(oprecision),
        .obaseaddr(obaseaddr), .ostride0(ostride0), .ostride1(ostride1),
        .ostride2(ostride2), .olength0(olength0), .olength1(olength1),
        .olength2(olength2), .quant_valid(quant_valid), .quant_word(quant_word),
        .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr),
        .wrd_word(wrd_word), .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          ph;
    logic [63:0] q[$];
    longint      written, total;
    bit          m_err;
    longint      m_prec, m_base, m_s0, m_s1, m_s2, m_l0, m_l1, m_l2;
    logic [14:0] wr_log[$];

    typedef struct {
        bit          st;
        bit          qv;
        logic [63:0] w;
        bit          en;
        logic [14:0] addr;
        logic [63:0] wd;
        bit          bsy;
        bit          dn;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Address of the idx-th write, from the nested-loop position it belongs to.
    function automatic logic [14:0] exp_addr(input longint idx);
        longint v, b, c0, c1, c2, a0, a1, s;
        v  = idx / m_prec;
        b  = idx % m_prec;
        c0 = v % (m_l0 + 1);
        c1 = (v / (m_l0 + 1)) % (m_l1 + 1);
        c2 = v / ((m_l0 + 1) * (m_l1 + 1));
        a0 = c0 + (c1 + c2 * (m_l1 + 1)) * m_l0;   // dim-0 advances so far
        a1 = c1 + c2 * m_l1;                        // dim-1 advances so far
        s  = m_base + a0 * m_s0 + a1 * m_s1 + c2 * m_s2 + b;
        return s[14:0];
    endfunction

    task automatic set_cfg(input int p, input int base, input int s0, input int s1,
                           input int s2, input int l0, input int l1, input int l2);
        oprecision = p[5:0];
        obaseaddr  = base[14:0];
        ostride0   = s0[14:0];
        ostride1   = s1[14:0];
        ostride2   = s2[14:0];
        olength0   = l0[14:0];
        olength1   = l1[14:0];
        olength2   = l2[14:0];
    endtask

    task automatic do_reset();
        clr = 1'b1; start = 1'b0; quant_valid = 1'b0; wrd_grnt = 1'b0; quant_word = '0;
        @(posedge clk); #1;
        chk("rst_wrd_en", wrd_en, 0);
        chk("rst_wrd_addr", wrd_addr, 0);
        chk("rst_wrd_word", wrd_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_ovf", err_ovf, 0);
        clr = 1'b0;
        ph = P_IDLE; q.delete(); m_err = 0; written = 0; total = 0;
    endtask

    // One clock of stimulus, checked against the model, then the model advances.
    task automatic step(input bit st, input bit qv, input logic [63:0] w, input bit g);
        bit en, pop, acc;
        start = st; quant_valid = qv; quant_word = w; wrd_grnt = g;
        en = (ph == P_RUN) && (q.size() > 0);
        chk("wrd_en", wrd_en, en);
        if (en) begin
            chk("wrd_addr", wrd_addr, exp_addr(written));
            chk("wrd_word", wrd_word, q[0]);
        end
        chk("busy", busy, (ph == P_RUN) || (ph == P_ZERO));
        chk("done", done, ph == P_DONE);
        chk("err_ovf", err_ovf, m_err);
        if (wrd_en && g) wr_log.push_back(wrd_addr);
        pop = en && g;
        if (st) begin
            q.delete(); m_err = 0; written = 0;
            m_prec = oprecision; m_base = obaseaddr;
            m_s0 = ostride0; m_s1 = ostride1; m_s2 = ostride2;
            m_l0 = olength0; m_l1 = olength1; m_l2 = olength2;
            total = m_prec * (m_l0 + 1) * (m_l1 + 1) * (m_l2 + 1);
            ph = (m_prec == 0) ? P_ZERO : P_RUN;
        end else begin
            acc = qv && (ph == P_RUN) && ((q.size() < DEPTH) || pop);
            if (qv && !acc) m_err = 1;
            if (ph == P_ZERO)      ph = P_DONE;
            else if (ph == P_DONE) ph = P_IDLE;
            if (pop) begin
                void'(q.pop_front());
                written++;
                if (written == total) ph = P_DONE;
            end
            if (acc) q.push_back(w);
        end
        @(posedge clk); #1;
    endtask

    logic [14:0] exp3d [8] = '{15'h000, 15'h001, 15'h011, 15'h012,
                               15'h112, 15'h113, 15'h123, 15'h124};

    initial begin
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // ---------------- Basic: table-driven ----------------
        tbl[0] = '{1, 0, 64'h0,                   0, 15'h000, 64'h0,                   0, 0};
        tbl[1] = '{0, 1, 64'hAAAA_0000_1111_000A, 0, 15'h000, 64'h0,                   1, 0};
        tbl[2] = '{0, 1, 64'hBBBB_0000_2222_000B, 1, 15'h100, 64'hAAAA_0000_1111_000A, 1, 0};
        tbl[3] = '{0, 1, 64'hCCCC_0000_3333_000C, 1, 15'h101, 64'hBBBB_0000_2222_000B, 1, 0};
        tbl[4] = '{0, 1, 64'hDDDD_0000_4444_000D, 1, 15'h102, 64'hCCCC_0000_3333_000C, 1, 0};
        tbl[5] = '{0, 1, 64'hEEEE_0000_5555_000E, 1, 15'h103, 64'hDDDD_0000_4444_000D, 1, 0};
        tbl[6] = '{0, 1, 64'hFFFF_0000_6666_000F, 1, 15'h104, 64'hEEEE_0000_5555_000E, 1, 0};
        tbl[7] = '{0, 0, 64'h0,                   1, 15'h105, 64'hFFFF_0000_6666_000F, 1, 0};
        tbl[8] = '{0, 0, 64'h0,                   0, 15'h000, 64'h0,                   0, 1};
        tbl[9] = '{0, 0, 64'h0,                   0, 15'h000, 64'h0,                   0, 0};
        set_cfg(2, 'h100, 2, 0, 0, 2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st; quant_valid = tbl[i].qv; quant_word = tbl[i].w; wrd_grnt = 1'b1;
            chk("tbl_wrd_en", wrd_en, tbl[i].en);
            if (tbl[i].en) begin
                chk("tbl_wrd_addr", wrd_addr, tbl[i].addr);
                chk("tbl_wrd_word", wrd_word, tbl[i].wd);
            end
            chk("tbl_busy", busy, tbl[i].bsy);
            chk("tbl_done", done, tbl[i].dn);
            chk("tbl_err_ovf", err_ovf, 0);
            @(posedge clk); #1;
        end
        do_reset();

        // ---------------- 3-D nesting ----------------
        set_cfg(1, 0, 1, 'h10, 'h100, 1, 1, 1);
        wr_log.delete();
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 64'h3D00 + 64'(i), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("nest_count", wr_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < wr_log.size()) chk("nest_addr", wr_log[i], exp3d[i]);

        // ---------------- Backpressure / overflow ----------------
        set_cfg(1, 'h40, 1, 0, 0, 7, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 64'hB0 + 64'(i), 0);
        chk("bp_err", err_ovf, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // ---------------- Full push + pop ----------------
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 64'hF0 + 64'(i), 0);
        step(0, 1, 64'hF4, 1);
        chk("fpp_err", err_ovf, 0);
        step(0, 1, 64'hF5, 0);       // still full: this one drops
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // ---------------- Wrap and restart ----------------
        set_cfg(2, 'h7FFF, 1, 0, 0, 1, 0, 0);
        wr_log.delete();
        step(1, 0, 0, 0);
        step(0, 1, 64'h57, 1);
        step(0, 1, 64'h58, 1);
        step(0, 0, 0, 1);
        chk("wrap_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("wrap_a0", wr_log[0], 15'h7FFF);
            chk("wrap_a1", wr_log[1], 15'h0000);
        end
        for (int i = 0; i < 5; i++) step(0, 1, 64'h60 + 64'(i), 0);
        set_cfg(1, 'h200, 1, 0, 0, 3, 0, 0);
        wr_log.delete();
        step(1, 0, 0, 0);
        chk("restart_err_clear", err_ovf, 0);
        step(0, 1, 64'h77, 1);
        step(0, 0, 0, 1);
        chk("restart_count", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("restart_addr", wr_log[0], 15'h200);

        // ---------------- oprecision = 0 ----------------
        set_cfg(0, 'h10, 1, 1, 1, 2, 2, 2);
        for (int i = 0; i < 4; i++) step(i == 0, 0, 0, 1);

        // ---------------- clr mid-run ----------------
        set_cfg(2, 'h123, 3, 0, 0, 3, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 64'hC1, 0);
        step(0, 1, 64'hC2, 0);
        do_reset();
        step(0, 0, 0, 1);

        // ---------------- Randomized jobs against the model ----------------
        for (int j = 0; j < 8; j++) begin
            int cyc;
            set_cfg($urandom_range(1, 4), $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
            step(1, 0, 0, 1);
            cyc = 0;
            while (ph != P_IDLE && cyc < 800) begin
                step(0, $urandom_range(0, 1) == 1, {$urandom, $urandom},
                     $urandom_range(0, 9) < 7);
                cyc++;
            end
            chk("rand_job_idle", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/outagu.md
Name: outagu

Overview:
- Output address generator and write buffer. Sits directly downstream of each MVU's quantizer.
- Accepts the bit-plane words the quantizer produces (N bits per word, MSB plane first) and buffers them in a small FIFO.
- Drives the MVU data-memory write port (wrd_en/wrd_addr/wrd_word) with a 3-D strided address pattern.
- Fills the currently tied-off wrd_* path; one instance per MVU in mvutop.

Parameters:
N, 64, word width (bits per bit-plane word)
BDBANKA, 15, data bank address width
BPREC, 6, precision field width
BLENGTH, 15, length field width
DEPTH, 4, FIFO depth in words (power of 2, >=2)

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
start  in  1  latch config, clear FIFO/counters, begin job
oprecision  in  BPREC  bits per output element (planes per vector), 0..32
obaseaddr  in  BDBANKA  output base address
ostride0/1/2  in  BDBANKA each  address increment per dim 0/1/2
olength0/1/2  in  BLENGTH each  dim length minus 1
quant_valid  in  1  quantizer word valid, one-cycle pulse per plane
quant_word  in  N  quantizer bit-plane word
wrd_en  out  1  write request
wrd_grnt  in  1  write granted this cycle
wrd_addr  out  BDBANKA  write address
wrd_word  out  N  write data
busy  out  1  job in progress
done  out  1  one-cycle pulse on job completion
err_ovf  out  1  sticky: word dropped (FIFO full or not RUN)

Behaviour:
- Reset (clr=1): state IDLE. FIFO empty; counters and ptr zero. wrd_en=0, wrd_addr=0, wrd_word=0, busy=0, done=0, err_ovf=0. clr overrides start.
- States:
  - IDLE -start-> RUN (or ZERO if oprecision==0)
  - ZERO -> DONE (no writes issued)
  - RUN -last pop-> DONE
  - DONE -> IDLE (done=1 for exactly this cycle)
- start in any state (including mid-RUN): registers all config, empties FIFO, zeroes bit/cnt0/cnt1/cnt2/ptr, clears err_ovf, enters RUN next cycle. In-flight words are discarded.
- busy=1 in RUN and ZERO.
- Push: quant_valid=1 in RUN. A push while FIFO full with no pop in the same cycle is dropped and sets err_ovf. Push and pop together when full is legal: no drop, occupancy unchanged.
- quant_valid outside RUN: word dropped, err_ovf set.
- Latency: word pushed at cycle t is visible as wrd_en/wrd_word at t+1 at the earliest. wrd_en = RUN & FIFO non-empty, combinational from registered state only. wrd_word = FIFO head.
- Pop occurs in any cycle with wrd_en & wrd_grnt. With wrd_grnt held high, one write per cycle is sustained.
- wrd_addr = obaseaddr + ptr + bit, modulo 2^BDBANKA (wrap silently).
- bit counts 0..oprecision-1. MSB plane is written at the lowest address.
- On each pop:
  - bit < oprecision-1: bit++.
  - Otherwise (vector complete) bit=0, then advance nested counters, odometer style:
    - cnt0 < olength0: cnt0++, ptr += ostride0.
    - else cnt0=0; cnt1 < olength1: cnt1++, ptr += ostride1.
    - else cnt1=0; cnt2 < olength2: cnt2++, ptr += ostride2.
    - else the job is complete: RUN->DONE.
- Strides are unsigned; a wrap-around sum gives effective negative strides.
- Total writes per job = oprecision × (olength0+1) × (olength1+1) × (olength2+1).
- Words arriving after the last pop are dropped and set err_ovf.

Decomposition:
- Shared package mvu_pkg holds: BDBANKA, BPREC, BLENGTH, and the state enum {IDLE, RUN, ZERO, DONE}.
- Sub-module outfifo (parameters N, DEPTH):
  - synchronous FIFO with push/pop, head data, full/empty flags;
  - simultaneous push+pop when full is legal;
  - clears on clr or flush.

Test Plan:
- Basic: oprecision=2, obaseaddr=0x100, olength0=2, olength1=olength2=0, ostride0=2, grant=1; 6 pulses with words A..F -> writes (0x100,A),(0x101,B),(0x102,C),(0x103,D),(0x104,E),(0x105,F). done pulses once the cycle after the F write; busy falls with it.
- 3-D nesting: oprecision=1, base 0, olength0=1, olength1=1, olength2=1, strides 1/0x10/0x100 -> addresses 0,1,0x11,0x12,0x112,0x113,0x123,0x124. Exactly 8 writes.
- Backpressure/overflow: DEPTH=4, grant=0; 5 consecutive pulses -> first 4 held and wrd_en=1, 5th dropped, err_ovf=1. Then grant=1 -> 4 writes in order, no corruption.
- Full push+pop: FIFO full, grant=1 and quant_valid=1 in the same cycle -> no drop, err_ovf stays 0, occupancy stays 4.
- Wrap and restart: obaseaddr=0x7FFF, oprecision=2 -> addresses 0x7FFF then 0x0000. Asserting start mid-job -> FIFO flushed, next write at new base, err_ovf cleared.
- Edge cases: oprecision=0 -> no wrd_en, done two cycles after start. clr asserted mid-RUN -> all outputs 0 next cycle.
